pll_clock_monitor: RTL and testbench

Companion to the board PLL instance. It runs in the PLL output clock domain and checks that the PLL is locked and producing the right frequency. It measures the PLL clock against a slow toggle derived from the 27 MHz board reference and sequences the system reset. Downstream logic is released from reset only after the PLL is locked and verified to be in-frequency. Reset is reasserted on any loss of lock or frequency fault.

---
 rtl/pll_clock_monitor.sv | 175 +++++++++++++++++
 tb/tb_pll_clock_monitor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_clock_monitor.sv
// PLL clock monitor: filters PLL lock, measures the PLL clock against a slow
// reference toggle and holds downstream logic in reset until the frequency is verified.
module pll_clock_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned EXP_MIN     = 465,
    parameter int unsigned EXP_MAX     = 486,
    parameter int unsigned GOOD_NEEDED = 4,
    parameter int unsigned RESET_HOLD  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock_async,
    input  logic             ref_toggle_async,
    output logic             sys_rst_out,
    output logic             clk_ok,
    output logic             fault,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid
);

    localparam int unsigned LCW = $clog2(LOCK_FILTER + 1);
    localparam int unsigned GCW = $clog2(GOOD_NEEDED + 1);
    localparam int unsigned HCW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [2:0] {
        StWaitLock,
        StMeasure,
        StHold,
        StRun,
        StFault
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] lock_sync_q, ref_sync_q;
    logic                   ref_s_d1_q;
    logic                   lock_s, ref_s, ref_edge;
    logic [LCW-1:0]         lock_cnt_q;
    logic                   lock_ok;
    logic [CNT_W-1:0]       cnt_q;
    logic                   interval_good, stall, edge_counted, good, bad;
    logic [GCW-1:0]         good_cnt_q, good_cnt_d;
    logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
    logic                   first_q, first_d;
    logic                   fault_d;

    assign lock_s   = lock_sync_q[SYNC_STAGES-1];
    assign ref_s    = ref_sync_q[SYNC_STAGES-1];
    assign ref_edge = ref_s ^ ref_s_d1_q;
    assign lock_ok  = (lock_cnt_q == LCW'(LOCK_FILTER));

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync_q <= '0;
            ref_sync_q  <= '0;
            ref_s_d1_q  <= 1'b0;
            lock_cnt_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock_async};
            ref_sync_q  <= {ref_sync_q[SYNC_STAGES-2:0], ref_toggle_async};
            ref_s_d1_q  <= ref_s;
            if (!lock_s) begin
                lock_cnt_q <= '0;
            end else if (!lock_ok) begin
                lock_cnt_q <= lock_cnt_q + 1'b1;
            end
        end
    end

    // Period counter runs in every state so a measurement is always available.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            meas_count <= '0;
            meas_valid <= 1'b0;
        end else if (ref_edge) begin
            cnt_q      <= CNT_W'(1);
            meas_count <= cnt_q;
            meas_valid <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign interval_good = (cnt_q >= CNT_W'(EXP_MIN)) && (cnt_q <= CNT_W'(EXP_MAX));
    assign stall         = !ref_edge && (cnt_q == CNT_W'(EXP_MAX + 1));
    // The first edge seen in MEASURE closes a partial interval and is not judged.
    assign edge_counted  = ref_edge && !((state_q == StMeasure) && first_q);
    assign good          = edge_counted && interval_good;
    assign bad           = (edge_counted && !interval_good) || stall;

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        hold_cnt_d = hold_cnt_q;
        fault_d    = fault;
        first_d    = first_q;
        unique case (state_q)
            StWaitLock: begin
                good_cnt_d = '0;
                if (lock_ok) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (!lock_ok) begin
                    state_d = StWaitLock;
                end else if (bad) begin
                    good_cnt_d = '0;
                end else if (good) begin
                    good_cnt_d = good_cnt_q + 1'b1;
                    if (good_cnt_q == GCW'(GOOD_NEEDED - 1)) begin
                        state_d    = StHold;
                        hold_cnt_d = '0;
                    end
                end
            end
            StHold: begin
                if (!lock_ok) begin
                    state_d = StWaitLock;
                end else if (bad) begin
                    state_d    = StMeasure;
                    good_cnt_d = '0;
                end else if (hold_cnt_q == HCW'(RESET_HOLD - 1)) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock_ok || bad) begin
                    state_d = StFault;
                    fault_d = 1'b1;
                end
            end
            StFault: begin
                state_d = StWaitLock;
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase
        if ((state_d == StMeasure) && (state_q != StMeasure)) begin
            first_d = 1'b1;
        end else if ((state_q == StMeasure) && ref_edge) begin
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitLock;
            good_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            first_q     <= 1'b0;
            fault       <= 1'b0;
            sys_rst_out <= 1'b1;
            clk_ok      <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            first_q     <= first_d;
            fault       <= fault_d;
            sys_rst_out <= (state_d != StRun);
            clk_ok      <= (state_d == StRun);
        end
    end

endmodule

// File: tb/tb_pll_clock_monitor.sv
// Scoreboard bench for pll_clock_monitor: a history/timestamp reference model predicts
// per-cycle outputs and measurement pulses; a monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_pll_clock_monitor;

    localparam int SYNC    = 2;
    localparam int LFILT   = 16;
    localparam int CW      = 12;
    localparam int EMIN    = 465;
    localparam int EMAX    = 486;
    localparam int GNEED   = 4;
    localparam int RHOLD   = 1024;
    localparam int MAXC    = 80000;
    localparam int SAT     = (1 << CW) - 1;

    localparam int MW = 0, MM = 1, MH = 2, MR = 3, MF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          lock_in;
    logic          ref_in;
    logic          sys_rst_out, clk_ok, fault, meas_valid;
    logic [CW-1:0] meas_count;

    pll_clock_monitor #(
        .SYNC_STAGES(SYNC), .LOCK_FILTER(LFILT), .CNT_W(CW), .EXP_MIN(EMIN),
        .EXP_MAX(EMAX), .GOOD_NEEDED(GNEED), .RESET_HOLD(RHOLD)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock_async(lock_in), .ref_toggle_async(ref_in),
        .sys_rst_out(sys_rst_out), .clk_ok(clk_ok), .fault(fault),
        .meas_count(meas_count), .meas_valid(meas_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sr;
        logic ok;
        logic f;
    } exp_t;

    exp_t exp_q[$];
    int   meas_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: raw input histories indexed by clock edge number.
    bit lraw [0:MAXC-1];
    bit fraw [0:MAXC-1];
    int n = -1;
    int rb = -1;
    int last_e = 0;
    int mstate = MW;
    int good_n = 0;
    int hold_entry = 0;
    bit partial = 0;
    bit mfault = 0;
    bit started = 0;

    function automatic bit lr(int j);
        return (j <= rb || j < 0) ? 1'b0 : lraw[j];
    endfunction

    function automatic bit fr(int j);
        return (j <= rb || j < 0) ? 1'b0 : fraw[j];
    endfunction

    task automatic model_step();
        int  c, cnt;
        bit  ok, edge_c, stall, counted, in_rng, good, bad;
        n++;
        if (n >= MAXC) begin
            $display("FAIL model_capacity cycles=%0d limit=%0d", n, MAXC);
            $fatal(1);
        end
        if (rst) begin
            rb = n; last_e = n; mstate = MW; good_n = 0; partial = 0; mfault = 0;
            started = 1;
            lraw[n] = 0; fraw[n] = 0;
            exp_q.push_back('{sr: 1'b1, ok: 1'b0, f: 1'b0});
            return;
        end
        lraw[n] = lock_in;
        fraw[n] = ref_in;
        if (!started) return;
        c = n - 1;
        // Lock is valid once the last LFILT synchronized samples were all high.
        ok = 1;
        for (int j = c - SYNC - LFILT + 1; j <= c - SYNC; j++) ok &= lr(j);
        edge_c = fr(c - SYNC + 1) != fr(c - SYNC);
        cnt = c - last_e;
        if (cnt > SAT) cnt = SAT;
        stall   = !edge_c && (cnt == EMAX + 1);
        counted = edge_c && !(mstate == MM && partial);
        in_rng  = (cnt >= EMIN) && (cnt <= EMAX);
        good    = counted && in_rng;
        bad     = (counted && !in_rng) || stall;
        case (mstate)
            MW: begin
                good_n = 0;
                if (ok) begin mstate = MM; partial = 1; end
            end
            MM: begin
                if (edge_c) partial = 0;
                if (!ok) mstate = MW;
                else if (bad) good_n = 0;
                else if (good) begin
                    good_n++;
                    if (good_n == GNEED) begin mstate = MH; hold_entry = n; end
                end
            end
            MH: begin
                if (!ok) mstate = MW;
                else if (bad) begin mstate = MM; good_n = 0; partial = 1; end
                else if (n - hold_entry == RHOLD) mstate = MR;
            end
            MR: begin
                if (!ok || bad) begin mstate = MF; mfault = 1; end
            end
            default: mstate = MW;
        endcase
        if (edge_c) begin
            meas_q.push_back(cnt);
            last_e = c;
        end
        exp_q.push_back('{sr: (mstate != MR), ok: (mstate == MR), f: mfault});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compares every predicted cycle and every measurement pulse.
    initial begin
        exp_t e;
        int   m;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({sys_rst_out, clk_ok, fault} !== {e.sr, e.ok, e.f}) begin
                    errors++;
                    $display("FAIL outputs t=%0t rst_ok_fault got=%b%b%b want=%b%b%b",
                             $time, sys_rst_out, clk_ok, fault, e.sr, e.ok, e.f);
                end
            end
            if (meas_valid === 1'b1 || meas_q.size() > 0) begin
                checks++;
                if (meas_q.size() == 0) begin
                    errors++;
                    $display("FAIL meas_unexpected t=%0t got=%0d want=none", $time, meas_count);
                end else begin
                    m = meas_q.pop_front();
                    if (meas_valid !== 1'b1 || meas_count !== CW'(m)) begin
                        errors++;
                        $display("FAIL meas t=%0t got valid=%b count=%0d want valid=1 count=%0d",
                                 $time, meas_valid, meas_count, m);
                    end
                end
            end
        end
    end

    // Reference toggle generator: explicit intervals first, then fixed or jittered period.
    int ref_period = 0;
    bit ref_jitter = 0;
    int per_q[$];
    initial begin
        int since, cur;
        ref_in = 0; since = 0; cur = 475;
        forever begin
            @(negedge clk);
            if (ref_period == 0 && per_q.size() == 0) begin
                since = 0;
            end else begin
                since++;
                if (since >= cur) begin
                    ref_in = ~ref_in;
                    since = 0;
                    if (per_q.size() > 0) cur = per_q.pop_front();
                    else if (ref_jitter) cur = $urandom_range(EMAX, EMIN);
                    else cur = ref_period;
                end
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_clk_ok(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (clk_ok === 1'b1) seen = 1;
        end
        check({name, "_timeout"}, int'(seen), 1);
    endtask

    task automatic wait_hold(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (mstate == MH) seen = 1;
        end
        check("hold_timeout", int'(seen), 1);
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        cycles(k);
        rst = 1'b0;
    endtask

    initial begin
        bit ok_seen;
        rst = 1'b1; lock_in = 1'b0;
        cycles(3);
        check("reset_sys_rst", int'(sys_rst_out), 1);
        check("reset_clk_ok", int'(clk_ok), 0);
        check("reset_meas_count", int'(meas_count), 0);

        // Nominal qualification at a fixed 475-cycle interval.
        ref_period = 475;
        rst = 1'b0;
        lock_in = 1'b1;
        wait_clk_ok(5000, "nominal");
        check("nominal_meas_count", int'(meas_count), 475);

        // One out-of-range interval during MEASURE delays release without faulting.
        do_reset(2);
        ref_jitter = 1;
        per_q = '{470, 480, 500, 466, 485, 475, 470, 481};
        wait_clk_ok(8000, "bad_interval");
        check("bad_interval_fault", int'(fault), 0);

        // Reference stops while running: stall fault, sticky across re-qualification.
        ref_period = 0;
        ref_jitter = 0;
        cycles(600);
        check("stall_fault", int'(fault), 1);
        check("stall_sys_rst", int'(sys_rst_out), 1);
        ref_period = 475;
        ref_jitter = 1;
        wait_clk_ok(6000, "requal_after_stall");
        check("stall_fault_sticky", int'(fault), 1);

        // One-cycle lock drop in RUN.
        lock_in = 1'b0;
        cycles(1);
        lock_in = 1'b1;
        cycles(3);
        check("lockdrop_sys_rst", int'(sys_rst_out), 1);
        check("lockdrop_fault", int'(fault), 1);
        wait_clk_ok(6000, "requal_after_lockdrop");

        // Lock glitching faster than the filter never qualifies.
        ok_seen = 0;
        for (int g = 0; g < 30; g++) begin
            lock_in = ~lock_in;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (clk_ok === 1'b1 && g > 0) ok_seen = 1;
            end
        end
        check("glitch_never_ok", int'(ok_seen), 0);
        lock_in = 1'b1;

        // Boundary intervals, then reset pulse while holding.
        do_reset(1);
        per_q = '{470, 465, 486, 464, 475, 487, 470, 465, 486, 475, 480};
        wait_hold(8000);
        cycles($urandom_range(900, 1));
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midhold_sys_rst", int'(sys_rst_out), 1);
        check("midhold_clk_ok", int'(clk_ok), 0);
        check("midhold_fault", int'(fault), 0);
        check("midhold_meas_valid", int'(meas_valid), 0);
        check("midhold_meas_count", int'(meas_count), 0);
        wait_clk_ok(6000, "requal_after_midhold");

        // Random intervals around the acceptance window.
        ref_jitter = 0;
        for (int r = 0; r < 12; r++) per_q.push_back($urandom_range(EMAX + 10, EMIN - 10));
        cycles(6500);

        cycles(5);
        check("meas_queue_drained", meas_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
